// File: rtl/biquad_seq_ctrl_if.sv
// biquad_seq_ctrl_if: control bundle between the biquad sequencer and the
// shared single-multiplier MAC datapath.
//   master : sequencer side (takes the sample tick, drives selects/strobes)
//   slave  : datapath / status side
// Optional: BIQUAD_OVR_CNT_EN adds the ovr_count status field.
interface biquad_seq_ctrl_if;

    // sample tick from the ADC-ready source
    logic       start;

    // MAC operand selects: result = muxZ + muxS * muxC
    logic [2:0] controlS;
    logic [1:0] controlC;
    logic [2:0] controlZ;

    // register load strobes
    logic       ld_uk;
    logic       ld_acum1;
    logic       ld_fk;
    logic       ld_acum2;
    logic       ld_acum3;
    logic       ld_yk;
    logic       shift_en;

    // status
    logic       busy;
    logic       done;
    logic       overrun;
`ifdef BIQUAD_OVR_CNT_EN
    logic [7:0] ovr_count;
`endif

    modport master (
        input  start,
        output controlS,
        output controlC,
        output controlZ,
        output ld_uk,
        output ld_acum1,
        output ld_fk,
        output ld_acum2,
        output ld_acum3,
        output ld_yk,
        output shift_en,
        output busy,
        output done,
        output overrun
`ifdef BIQUAD_OVR_CNT_EN
        , output ovr_count
`endif
    );

    modport slave (
        output start,
        input  controlS,
        input  controlC,
        input  controlZ,
        input  ld_uk,
        input  ld_acum1,
        input  ld_fk,
        input  ld_acum2,
        input  ld_acum3,
        input  ld_yk,
        input  shift_en,
        input  busy,
        input  done,
        input  overrun
`ifdef BIQUAD_OVR_CNT_EN
        , input ovr_count
`endif
    );

endinterface

// File: rtl/biquad_seq_ctrl.sv
// biquad_seq_ctrl: sequencer for the shared single-multiplier direct-form-II
// biquad. One start pulse walks the datapath through the five MAC steps,
// the state shift and a done pulse, producing one output sample yk.
// MUL_LAT (0..7) stretches every MAC step to MUL_LAT+1 cycles so a
// pipelined multiply-add has settled before its result is strobed.
// Optional: define BIQUAD_OVR_CNT_EN to add the 8-bit saturating ovr_count.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start, all selects and strobes 0
// LOAD_U  | capture new input sample Uk (ld_uk)
// MAC1    | acum1 = Uk    + a1*fk1
// MAC2    | fk    = acum1 + a2*fk2
// MAC3    | acum2 = 0     + b0*fk
// MAC4    | acum3 = acum2 + b1*fk1
// MAC5    | yk    = acum3 + b2*fk2
// SHIFT   | fk2 <= fk1, fk1 <= fk
// DONE    | one-cycle done pulse, yk is valid
module biquad_seq_ctrl #(
    parameter int MUL_LAT = 0
) (
    input  logic              clk,
    input  logic              reset,
    biquad_seq_ctrl_if.master bus
);

    // coefficient select codes
    localparam logic [2:0] S_ZERO = 3'b000;
    localparam logic [2:0] S_A1   = 3'b001;
    localparam logic [2:0] S_A2   = 3'b010;
    localparam logic [2:0] S_B0   = 3'b011;
    localparam logic [2:0] S_B1   = 3'b100;
    localparam logic [2:0] S_B2   = 3'b101;

    // state select codes
    localparam logic [1:0] C_ZERO = 2'b00;
    localparam logic [1:0] C_FK1  = 2'b01;
    localparam logic [1:0] C_FK2  = 2'b10;
    localparam logic [1:0] C_FK   = 2'b11;

    // addend select codes
    localparam logic [2:0] Z_ZERO  = 3'b000;
    localparam logic [2:0] Z_UK    = 3'b001;
    localparam logic [2:0] Z_YK    = 3'b010;
    localparam logic [2:0] Z_ACUM1 = 3'b011;
    localparam logic [2:0] Z_ACUM2 = 3'b100;
    localparam logic [2:0] Z_ACUM3 = 3'b101;

    // last hold count of a MAC step; MUL_LAT outside 0..7 is not supported
    localparam logic [2:0] HOLD_LAST = 3'(MUL_LAT);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD_U = 4'd1,
        ST_MAC1   = 4'd2,
        ST_MAC2   = 4'd3,
        ST_MAC3   = 4'd4,
        ST_MAC4   = 4'd5,
        ST_MAC5   = 4'd6,
        ST_SHIFT  = 4'd7,
        ST_DONE   = 4'd8
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] hold_cnt;
    logic [2:0] hold_cnt_nxt;
    logic       hold_done;
    logic       mac_last_nxt;
    logic       start_ignored;

    // registered outputs and their next values
    logic [2:0] sel_s_q,    sel_s_d;
    logic [1:0] sel_c_q,    sel_c_d;
    logic [2:0] sel_z_q,    sel_z_d;
    logic       ld_uk_q,    ld_uk_d;
    logic       ld_acum1_q, ld_acum1_d;
    logic       ld_fk_q,    ld_fk_d;
    logic       ld_acum2_q, ld_acum2_d;
    logic       ld_acum3_q, ld_acum3_d;
    logic       ld_yk_q,    ld_yk_d;
    logic       shift_q,    shift_d;
    logic       busy_q,     busy_d;
    logic       done_q,     done_d;
    logic       overrun_q;

    assign hold_done     = (hold_cnt == HOLD_LAST);
    assign start_ignored = bus.start && (state != ST_IDLE);

    // next-state and hold counter: MAC steps dwell until the counter hits
    // HOLD_LAST; the counter returns to 0 on every state entry
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = '0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt = ST_LOAD_U;
                end
            end
            ST_LOAD_U: state_nxt = ST_MAC1;
            ST_MAC1: begin
                if (hold_done) state_nxt = ST_MAC2;
                else           hold_cnt_nxt = hold_cnt + 3'd1;
            end
            ST_MAC2: begin
                if (hold_done) state_nxt = ST_MAC3;
                else           hold_cnt_nxt = hold_cnt + 3'd1;
            end
            ST_MAC3: begin
                if (hold_done) state_nxt = ST_MAC4;
                else           hold_cnt_nxt = hold_cnt + 3'd1;
            end
            ST_MAC4: begin
                if (hold_done) state_nxt = ST_MAC5;
                else           hold_cnt_nxt = hold_cnt + 3'd1;
            end
            ST_MAC5: begin
                if (hold_done) state_nxt = ST_SHIFT;
                else           hold_cnt_nxt = hold_cnt + 3'd1;
            end
            ST_SHIFT: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign mac_last_nxt = (hold_cnt_nxt == HOLD_LAST);

    // output decode of the upcoming state so the registered outputs line up
    // with the state they describe; a MAC strobe fires only on its last cycle
    always_comb begin
        sel_s_d    = S_ZERO;
        sel_c_d    = C_ZERO;
        sel_z_d    = Z_ZERO;
        ld_uk_d    = 1'b0;
        ld_acum1_d = 1'b0;
        ld_fk_d    = 1'b0;
        ld_acum2_d = 1'b0;
        ld_acum3_d = 1'b0;
        ld_yk_d    = 1'b0;
        shift_d    = 1'b0;
        done_d     = 1'b0;
        busy_d     = (state_nxt != ST_IDLE);
        case (state_nxt)
            ST_LOAD_U: ld_uk_d = 1'b1;
            ST_MAC1: begin
                sel_s_d    = S_A1;
                sel_c_d    = C_FK1;
                sel_z_d    = Z_UK;
                ld_acum1_d = mac_last_nxt;
            end
            ST_MAC2: begin
                sel_s_d = S_A2;
                sel_c_d = C_FK2;
                sel_z_d = Z_ACUM1;
                ld_fk_d = mac_last_nxt;
            end
            ST_MAC3: begin
                sel_s_d    = S_B0;
                sel_c_d    = C_FK;
                sel_z_d    = Z_ZERO;
                ld_acum2_d = mac_last_nxt;
            end
            ST_MAC4: begin
                sel_s_d    = S_B1;
                sel_c_d    = C_FK1;
                sel_z_d    = Z_ACUM2;
                ld_acum3_d = mac_last_nxt;
            end
            ST_MAC5: begin
                sel_s_d = S_B2;
                sel_c_d = C_FK2;
                sel_z_d = Z_ACUM3;
                ld_yk_d = mac_last_nxt;
            end
            ST_SHIFT: shift_d = 1'b1;
            ST_DONE:  done_d  = 1'b1;
            default: ;
        endcase
    end

    // state register and hold counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // output registers; reset drops every strobe on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_s_q    <= S_ZERO;
            sel_c_q    <= C_ZERO;
            sel_z_q    <= Z_ZERO;
            ld_uk_q    <= 1'b0;
            ld_acum1_q <= 1'b0;
            ld_fk_q    <= 1'b0;
            ld_acum2_q <= 1'b0;
            ld_acum3_q <= 1'b0;
            ld_yk_q    <= 1'b0;
            shift_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            sel_s_q    <= sel_s_d;
            sel_c_q    <= sel_c_d;
            sel_z_q    <= sel_z_d;
            ld_uk_q    <= ld_uk_d;
            ld_acum1_q <= ld_acum1_d;
            ld_fk_q    <= ld_fk_d;
            ld_acum2_q <= ld_acum2_d;
            ld_acum3_q <= ld_acum3_d;
            ld_yk_q    <= ld_yk_d;
            shift_q    <= shift_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // sticky overrun: a start outside IDLE is dropped but remembered
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (start_ignored) begin
            overrun_q <= 1'b1;
        end
    end

`ifdef BIQUAD_OVR_CNT_EN
    logic [7:0] ovr_count_q;

    // saturating count of dropped start pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr_count_q <= '0;
        end else if (start_ignored && (ovr_count_q != 8'hFF)) begin
            ovr_count_q <= ovr_count_q + 8'd1;
        end
    end

    assign bus.ovr_count = ovr_count_q;
`endif

    assign bus.controlS = sel_s_q;
    assign bus.controlC = sel_c_q;
    assign bus.controlZ = sel_z_q;
    assign bus.ld_uk    = ld_uk_q;
    assign bus.ld_acum1 = ld_acum1_q;
    assign bus.ld_fk    = ld_fk_q;
    assign bus.ld_acum2 = ld_acum2_q;
    assign bus.ld_acum3 = ld_acum3_q;
    assign bus.ld_yk    = ld_yk_q;
    assign bus.shift_en = shift_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_biquad_seq_ctrl.sv
// tb_biquad_seq_ctrl: scoreboard bench for biquad_seq_ctrl. Two instances
// (MUL_LAT=0 and MUL_LAT=2); the stimulus pushes the expected output word
// for each cycle, a negedge monitor pops and compares.
module tb_biquad_seq_ctrl;

    localparam int NEVER = 1 << 30;

    // expected MAC step table, steps 1..5
    localparam logic [2:0] TAB_S [5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
    localparam logic [1:0] TAB_C [5] = '{2'b01,  2'b10,  2'b11,  2'b01,  2'b10};
    localparam logic [2:0] TAB_Z [5] = '{3'b001, 3'b011, 3'b000, 3'b100, 3'b101};

    typedef struct {
        int          cyc;
        logic [17:0] vec;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;
    bit   mon_en;
    bit   drain_req;
    bit   drain_done;

    exp_t q0[$];
    exp_t q2[$];
    exp_t qc[$];

    biquad_seq_ctrl_if bus0();
    biquad_seq_ctrl_if bus2();

    biquad_seq_ctrl #(.MUL_LAT(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    biquad_seq_ctrl #(.MUL_LAT(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    // {S,C,Z,ld_uk,ld_acum1,ld_fk,ld_acum2,ld_acum3,ld_yk,shift_en,busy,done,overrun}
    logic [17:0] obs0;
    logic [17:0] obs2;
    assign obs0 = {bus0.controlS, bus0.controlC, bus0.controlZ, bus0.ld_uk,
                   bus0.ld_acum1, bus0.ld_fk, bus0.ld_acum2, bus0.ld_acum3,
                   bus0.ld_yk, bus0.shift_en, bus0.busy, bus0.done, bus0.overrun};
    assign obs2 = {bus2.controlS, bus2.controlC, bus2.controlZ, bus2.ld_uk,
                   bus2.ld_acum1, bus2.ld_fk, bus2.ld_acum2, bus2.ld_acum3,
                   bus2.ld_yk, bus2.shift_en, bus2.busy, bus2.done, bus2.overrun};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int n);
        while (cyc < n) tick();
    endtask

    task automatic add_exp(input int which, input int c, input logic [17:0] v,
                           input int ovr_from, input int upto);
        exp_t e;
        if (c > upto) return;
        e.cyc    = c;
        e.vec    = v;
        e.vec[0] = (c >= ovr_from);
        if (which == 0) q0.push_back(e);
        else            q2.push_back(e);
    endtask

    task automatic push_idle(input int which, input int c, input logic ovr);
        add_exp(which, c, 18'd0, ovr ? 0 : NEVER, NEVER);
    endtask

    // one full sequence for a start sampled in cycle k
    task automatic push_seq(input int which, input int k, input int lat,
                            input int ovr_from, input int upto);
        logic [17:0] v;
        int c;
        v = '0; v[9] = 1'b1; v[2] = 1'b1;
        add_exp(which, k + 1, v, ovr_from, upto);
        for (int m = 0; m < 5; m++) begin
            for (int h = 0; h <= lat; h++) begin
                v = '0;
                v[17:15] = TAB_S[m];
                v[14:13] = TAB_C[m];
                v[12:10] = TAB_Z[m];
                v[2]     = 1'b1;
                if (h == lat) v[8 - m] = 1'b1;
                add_exp(which, k + 2 + m * (lat + 1) + h, v, ovr_from, upto);
            end
        end
        c = k + 2 + 5 * (lat + 1);
        v = '0; v[3] = 1'b1; v[2] = 1'b1;
        add_exp(which, c, v, ovr_from, upto);
        v = '0; v[1] = 1'b1; v[2] = 1'b1;
        add_exp(which, c + 1, v, ovr_from, upto);
    endtask

    task automatic push_cnt(input int c, input logic [7:0] val);
        exp_t e;
        e.cyc = c;
        e.vec = {10'd0, val};
        qc.push_back(e);
    endtask

    // monitor: compares whenever a DUT presents activity or an entry is due
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en && ((obs0[17:1] != '0) || (q0.size() != 0 && q0[0].cyc == cyc))) begin
            total = total + 1;
            if (q0.size() == 0) begin
                bad = bad + 1;
                $display("FAIL sb0_extra cyc=%0d got=%b want=none", cyc, obs0);
            end else begin
                e = q0.pop_front();
                if (e.cyc != cyc || e.vec !== obs0) begin
                    bad = bad + 1;
                    $display("FAIL sb0_out cyc=%0d got=%b want=%b (due cyc %0d)",
                             cyc, obs0, e.vec, e.cyc);
                end
            end
        end
        if ((obs2[17:1] != '0) || (q2.size() != 0 && q2[0].cyc == cyc)) begin
            total = total + 1;
            if (q2.size() == 0) begin
                bad = bad + 1;
                $display("FAIL sb2_extra cyc=%0d got=%b want=none", cyc, obs2);
            end else begin
                e = q2.pop_front();
                if (e.cyc != cyc || e.vec !== obs2) begin
                    bad = bad + 1;
                    $display("FAIL sb2_out cyc=%0d got=%b want=%b (due cyc %0d)",
                             cyc, obs2, e.vec, e.cyc);
                end
            end
        end
`ifdef BIQUAD_OVR_CNT_EN
        if (qc.size() != 0 && qc[0].cyc == cyc) begin
            e = qc.pop_front();
            total = total + 1;
            if (bus0.ovr_count !== e.vec[7:0]) begin
                bad = bad + 1;
                $display("FAIL ovr_count cyc=%0d got=%0d want=%0d", cyc, bus0.ovr_count, e.vec[7:0]);
            end
        end
`endif
        if (drain_req && !drain_done) begin
            total = total + 1;
            if (q0.size() + q2.size() + qc.size() != 0) begin
                bad = bad + 1;
                $display("FAIL sb_drain got=%0d/%0d/%0d pending want=0",
                         q0.size(), q2.size(), qc.size());
            end
            drain_done = 1'b1;
        end
    end

    initial begin
        total      = 0;
        bad        = 0;
        mon_en     = 1'b1;
        drain_req  = 1'b0;
        drain_done = 1'b0;
        reset      = 1'b1;
        bus0.start = 1'b0;
        bus2.start = 1'b0;

        // reset then five idle cycles
        for (int c = 4; c <= 8; c++) begin
            push_idle(0, c, 1'b0);
            push_idle(2, c, 1'b0);
        end
        goto(3);
        reset = 1'b0;

        // MUL_LAT=0 single sample, start in cycle 10
        push_seq(0, 10, 0, NEVER, NEVER);
        push_idle(0, 19, 1'b0);
        goto(10);
        bus0.start = 1'b1; tick(); bus0.start = 1'b0;

        // MUL_LAT=2 single sample, done at 30+18
        goto(20);
        push_seq(2, 30, 2, NEVER, NEVER);
        push_idle(2, 49, 1'b0);
        goto(30);
        bus2.start = 1'b1; tick(); bus2.start = 1'b0;

        // second start while busy is dropped; third after DONE runs normally
        goto(50);
        push_seq(0, 60, 0, 65, NEVER);
        push_idle(0, 69, 1'b1);
        push_seq(0, 69, 0, 0, NEVER);
        push_idle(0, 78, 1'b1);
        goto(60);
        bus0.start = 1'b1; tick(); bus0.start = 1'b0;
        goto(64);
        bus0.start = 1'b1; tick(); bus0.start = 1'b0;
        goto(69);
        bus0.start = 1'b1; tick(); bus0.start = 1'b0;

        // start held high: back-to-back sequences from each IDLE cycle
        push_seq(0, 80, 0, 0, NEVER);
        push_seq(0, 89, 0, 0, NEVER);
        push_idle(0, 98, 1'b1);
        goto(80);
        bus0.start = 1'b1;
        goto(90);
        bus0.start = 1'b0;

        // reset during MAC3, then a clean sequence
        goto(100);
        push_seq(0, 110, 0, 0, 114);
        push_idle(0, 115, 1'b0);
        push_idle(2, 115, 1'b0);
        push_seq(0, 120, 0, NEVER, NEVER);
        push_idle(0, 129, 1'b0);
        goto(110);
        bus0.start = 1'b1; tick(); bus0.start = 1'b0;
        goto(114);
        reset = 1'b1;
        goto(115);
        reset = 1'b0;
        goto(120);
        bus0.start = 1'b1; tick(); bus0.start = 1'b0;

        // MUL_LAT=2 overrun during MAC2
        goto(130);
        push_seq(2, 140, 2, 146, NEVER);
        push_idle(2, 159, 1'b1);
        goto(140);
        bus2.start = 1'b1; tick(); bus2.start = 1'b0;
        goto(145);
        bus2.start = 1'b1; tick(); bus2.start = 1'b0;
        goto(162);

`ifdef BIQUAD_OVR_CNT_EN
        // dropped-start counter: 8 drops over one sequence, then saturation
        mon_en = 1'b0;
        goto(170);
        reset = 1'b1;
        push_cnt(172, 8'd0);
        goto(171);
        reset = 1'b0;
        goto(175);
        bus0.start = 1'b1;
        goto(184);
        bus0.start = 1'b0;
        push_cnt(186, 8'd8);
        goto(190);
        bus0.start = 1'b1;
        goto(590);
        bus0.start = 1'b0;
        push_cnt(600, 8'd255);
        goto(601);
        reset = 1'b1;
        goto(602);
        reset = 1'b0;
        push_cnt(603, 8'd0);
        goto(605);
        mon_en = 1'b1;
`endif

        drain_req = 1'b1;
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "bench did not finish");
    end

endmodule
